// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//
// Purpose:
//   General-purpose register file with two registered read ports and one
//   write port. It also keeps a per-register pending-write scoreboard, which
//   lets the stage sequencer stall on operands whose producer has not yet
//   written back.
//
// Parameters:
//   NUM_REGS   - number of architectural registers (2..32)
//   ADDR_WIDTH - register index width
//   DATA_WIDTH - register data width
//   BYPASS     - 1: a same-cycle write forwards to the read ports and hides
//                busy; 0: no forwarding
//
// Ports:
//   clk            - system clock; all state updates on the rising edge
//   rst            - synchronous active-high reset
//   write_address  - destination register for a write
//   write_data     - data to write
//   write_enable   - commit write_data to write_address at the edge
//   read_reg_0/1   - read port selects
//   read_data_0/1  - registered read data (1-cycle latency)
//   reserve_enable - mark reserve_reg as having a pending write
//   reserve_reg    - register to mark busy
//   read_busy_0/1  - combinational pending-write flag for read_reg_0/1
//   debug_addr     - inspection index
//   debug_data     - combinational raw contents of regs[debug_addr]
// ----------------------------------------------------------------------------
module register_file #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] read_reg_0,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    output logic [DATA_WIDTH-1:0] read_data_0,
    output logic [DATA_WIDTH-1:0] read_data_1,
    input  logic                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0] reserve_reg,
    output logic                  read_busy_0,
    output logic                  read_busy_1,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data
);

    // Index width that exactly covers the storage array; the full address is
    // only used for the range check.
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // One bit wider than an address so the range compare never degenerates
    // into a constant when NUM_REGS == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = NUM_REGS[ADDR_WIDTH:0];

    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic [DATA_WIDTH-1:0] r_readData0;
    logic [DATA_WIDTH-1:0] r_readData1;

    logic                  w_wrInRange;
    logic                  w_rsvInRange;
    logic                  w_rd0InRange;
    logic                  w_rd1InRange;
    logic                  w_dbgInRange;
    logic [IDX_W-1:0]      w_wrIdx;
    logic [IDX_W-1:0]      w_rsvIdx;
    logic [IDX_W-1:0]      w_rd0Idx;
    logic [IDX_W-1:0]      w_rd1Idx;
    logic [IDX_W-1:0]      w_dbgIdx;
    logic                  w_fwd0;
    logic                  w_fwd1;
    logic [DATA_WIDTH-1:0] w_value0;
    logic [DATA_WIDTH-1:0] w_value1;

    assign w_wrInRange  = ({1'b0, write_address} < NUM_REGS_EXT);
    assign w_rsvInRange = ({1'b0, reserve_reg}   < NUM_REGS_EXT);
    assign w_rd0InRange = ({1'b0, read_reg_0}    < NUM_REGS_EXT);
    assign w_rd1InRange = ({1'b0, read_reg_1}    < NUM_REGS_EXT);
    assign w_dbgInRange = ({1'b0, debug_addr}    < NUM_REGS_EXT);

    assign w_wrIdx  = write_address[IDX_W-1:0];
    assign w_rsvIdx = reserve_reg[IDX_W-1:0];
    assign w_rd0Idx = read_reg_0[IDX_W-1:0];
    assign w_rd1Idx = read_reg_1[IDX_W-1:0];
    assign w_dbgIdx = debug_addr[IDX_W-1:0];

    // A write landing on the selected register this cycle. Equality with an
    // in-range read select implies the write address is in range too.
    assign w_fwd0 = BYPASS_EN && write_enable && (write_address == read_reg_0);
    assign w_fwd1 = BYPASS_EN && write_enable && (write_address == read_reg_1);

    // Value each read port will capture at the next edge: zero when out of
    // range, forwarded write data when bypassing, otherwise stored contents.
    always_comb begin
        w_value0 = '0;
        w_value1 = '0;
        if (w_rd0InRange) begin
            w_value0 = w_fwd0 ? write_data : r_regs[w_rd0Idx];
        end
        if (w_rd1InRange) begin
            w_value1 = w_fwd1 ? write_data : r_regs[w_rd1Idx];
        end
    end

    // Register storage. Register 0 is an ordinary writable register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (write_enable && w_wrInRange) begin
            r_regs[w_wrIdx] <= write_data;
        end
    end

    // Pending-write scoreboard. The reserve assignment comes after the
    // clear, so a new producer reserving the register being written back
    // keeps it busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (write_enable && w_wrInRange) begin
                r_busy[w_wrIdx] <= 1'b0;
            end
            if (reserve_enable && w_rsvInRange) begin
                r_busy[w_rsvIdx] <= 1'b1;
            end
        end
    end

    // Registered read ports with one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_readData0 <= '0;
            r_readData1 <= '0;
        end else begin
            r_readData0 <= w_value0;
            r_readData1 <= w_value1;
        end
    end

    assign read_data_0 = r_readData0;
    assign read_data_1 = r_readData1;

    // A write completing this cycle hides the busy flag when forwarding,
    // because the consumer will capture the forwarded value.
    assign read_busy_0 = w_rd0InRange && r_busy[w_rd0Idx] && !w_fwd0;
    assign read_busy_1 = w_rd1InRange && r_busy[w_rd1Idx] && !w_fwd1;

    // Debug view of committed state only; never forwarded.
    assign debug_data = w_dbgInRange ? r_regs[w_dbgIdx] : '0;

endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
//
// Purpose:
//   Drives two register_file instances with the same stimulus: instance A
//   (32 registers, forwarding on) and instance B (16 registers, forwarding
//   off). A reference model predicts every output. The expected values for
//   each cycle are queued, and an independent monitor compares them against
//   the DUT outputs.
// ----------------------------------------------------------------------------
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [4:0]  read_reg_0;
    logic [4:0]  read_reg_1;
    logic        reserve_enable;
    logic [4:0]  reserve_reg;
    logic [4:0]  debug_addr;

    logic [31:0] aReadData0, aReadData1, aDebugData;
    logic        aBusy0, aBusy1;
    logic [31:0] bReadData0, bReadData1, bDebugData;
    logic        bBusy0, bBusy1;

    int checks   = 0;
    int failures = 0;

    // Expected outputs for one cycle, for both instances (index 0 = A, 1 = B).
    typedef struct packed {
        logic [1:0][31:0] rd0;
        logic [1:0][31:0] rd1;
        logic [1:0][31:0] dbg;
        logic [1:0]       busy0;
        logic [1:0]       busy1;
    } expT;

    expT expQ[$];

    // Reference model state for both configurations.
    logic [31:0] mRegs [2][32];
    bit          mBusy [2][32];
    logic [31:0] mRd0  [2];
    logic [31:0] mRd1  [2];

    register_file #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1)) dutA (
        .clk(clk), .rst(rst),
        .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
        .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
        .read_data_0(aReadData0), .read_data_1(aReadData1),
        .reserve_enable(reserve_enable), .reserve_reg(reserve_reg),
        .read_busy_0(aBusy0), .read_busy_1(aBusy1),
        .debug_addr(debug_addr), .debug_data(aDebugData)
    );

    register_file #(.NUM_REGS(16), .ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(0)) dutB (
        .clk(clk), .rst(rst),
        .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
        .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
        .read_data_0(bReadData0), .read_data_1(bReadData1),
        .reserve_enable(reserve_enable), .reserve_reg(reserve_reg),
        .read_busy_0(bBusy0), .read_busy_1(bBusy1),
        .debug_addr(debug_addr), .debug_data(bDebugData)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cfgRegs(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic bit cfgBypass(input int k);
        return (k == 0);
    endfunction

    // Clears one configuration of the model to its post-reset state.
    task automatic modelReset(input int k);
        for (int r = 0; r < 32; r++) begin
            mRegs[k][r] = 32'h0;
            mBusy[k][r] = 1'b0;
        end
        mRd0[k] = 32'h0;
        mRd1[k] = 32'h0;
    endtask

    // Value a read of address a would capture this cycle.
    function automatic logic [31:0] modelValue(input int k, input int a, input bit we,
                                               input int wa, input logic [31:0] wd);
        if (a >= cfgRegs(k)) return 32'h0;
        if (cfgBypass(k) && we && wa == a) return wd;
        return mRegs[k][a];
    endfunction

    function automatic bit modelBusy(input int k, input int a, input bit we, input int wa);
        if (a >= cfgRegs(k)) return 1'b0;
        return mBusy[k][a] && !(cfgBypass(k) && we && wa == a);
    endfunction

    // Drives one cycle of inputs (just after a rising edge), queues the
    // outputs expected during that cycle, advances the model across the next
    // edge, then waits for that edge.
    task automatic applyStimulus(input bit iRst, input bit iWe, input int iWa, input logic [31:0] iWd,
                                 input int iR0, input int iR1, input bit iRe, input int iRr,
                                 input int iDbg);
        expT e;
        logic [31:0] nRd0, nRd1;
        rst            = iRst;
        write_enable   = iWe;
        write_address  = 5'(iWa);
        write_data     = iWd;
        read_reg_0     = 5'(iR0);
        read_reg_1     = 5'(iR1);
        reserve_enable = iRe;
        reserve_reg    = 5'(iRr);
        debug_addr     = 5'(iDbg);
        for (int k = 0; k < 2; k++) begin
            e.rd0[k]   = mRd0[k];
            e.rd1[k]   = mRd1[k];
            e.dbg[k]   = (iDbg < cfgRegs(k)) ? mRegs[k][iDbg] : 32'h0;
            e.busy0[k] = modelBusy(k, iR0, iWe, iWa);
            e.busy1[k] = modelBusy(k, iR1, iWe, iWa);
        end
        expQ.push_back(e);
        for (int k = 0; k < 2; k++) begin
            if (iRst) begin
                modelReset(k);
            end else begin
                nRd0 = modelValue(k, iR0, iWe, iWa, iWd);
                nRd1 = modelValue(k, iR1, iWe, iWa, iWd);
                if (iWe && iWa < cfgRegs(k)) begin
                    mRegs[k][iWa] = iWd;
                    mBusy[k][iWa] = 1'b0;
                end
                if (iRe && iRr < cfgRegs(k)) begin
                    mBusy[k][iRr] = 1'b1;
                end
                mRd0[k] = nRd0;
                mRd1[k] = nRd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: mid-cycle, the registered outputs reflect the previous edge
    // and the combinational outputs reflect the current inputs.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("A.read_data_0", aReadData0, e.rd0[0]);
                checkOutput("A.read_data_1", aReadData1, e.rd1[0]);
                checkOutput("A.debug_data",  aDebugData, e.dbg[0]);
                checkOutput("A.read_busy_0", {31'h0, aBusy0}, {31'h0, e.busy0[0]});
                checkOutput("A.read_busy_1", {31'h0, aBusy1}, {31'h0, e.busy1[0]});
                checkOutput("B.read_data_0", bReadData0, e.rd0[1]);
                checkOutput("B.read_data_1", bReadData1, e.rd1[1]);
                checkOutput("B.debug_data",  bDebugData, e.dbg[1]);
                checkOutput("B.read_busy_0", {31'h0, bBusy0}, {31'h0, e.busy0[1]});
                checkOutput("B.read_busy_1", {31'h0, bBusy1}, {31'h0, e.busy1[1]});
            end
        end
    end

    // Small address pool most of the time so hazards and collisions occur.
    function automatic int pickAddr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 7));
    endfunction

    // Directed scenarios first, then randomized traffic, then drain.
    initial begin
        rst = 1'b1; write_enable = 1'b0; write_address = '0; write_data = '0;
        read_reg_0 = '0; read_reg_1 = '0; reserve_enable = 1'b0; reserve_reg = '0;
        debug_addr = '0;
        @(posedge clk);
        #1;
        modelReset(0);
        modelReset(1);

        // Populate state, then reset in the middle of a write and a reserve.
        applyStimulus(0, 1, 3, 32'h11111111, 3, 6, 1, 6, 3);
        applyStimulus(0, 0, 0, 32'h0,        3, 6, 1, 3, 3);
        applyStimulus(1, 1, 3, 32'hDEADBEEF, 3, 6, 1, 6, 3);
        applyStimulus(0, 0, 0, 32'h0,        3, 6, 0, 0, 3);

        // Basic write and read back through port 0 and the debug port.
        applyStimulus(0, 1, 5, 32'h12345678, 0, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 32'h0,        5, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 32'h0,        5, 5, 0, 0, 5);

        // Same-edge write and read of r7 (forwarded in A, old value in B).
        applyStimulus(0, 1, 7, 32'hA5A5A5A5, 0, 7, 0, 0, 7);
        applyStimulus(0, 0, 0, 32'h0,        7, 7, 0, 0, 7);

        // Reserve r9, then complete its write while it is being read.
        applyStimulus(0, 0, 0, 32'h0,        9, 0, 1, 9, 9);
        applyStimulus(0, 0, 0, 32'h0,        9, 9, 0, 0, 9);
        applyStimulus(0, 1, 9, 32'h0BADF00D, 9, 9, 0, 0, 9);
        applyStimulus(0, 0, 0, 32'h0,        9, 9, 0, 0, 9);

        // Write-back and new reservation of r4 in the same cycle.
        applyStimulus(0, 0, 0, 32'h0,        4, 4, 1, 4, 4);
        applyStimulus(0, 1, 4, 32'hCAFE0004, 4, 4, 1, 4, 4);
        applyStimulus(0, 0, 0, 32'h0,        4, 4, 0, 0, 4);

        // Out-of-range address 20 for the 16-register instance.
        applyStimulus(0, 1, 20, 32'hFFFFFFFF, 20, 20, 1, 20, 20);
        applyStimulus(0, 0, 0,  32'h0,        20, 20, 0, 0,  20);
        applyStimulus(0, 0, 0,  32'h0,        20, 4,  0, 0,  20);

        // Register 0 is writable.
        applyStimulus(0, 1, 0, 32'h00C0FFEE, 0, 31, 1, 31, 0);
        applyStimulus(0, 0, 0, 32'h0,        0, 31, 0, 0,  31);

        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 79) == 0,
                          1'($urandom_range(0, 1)), pickAddr(), $urandom(),
                          pickAddr(), pickAddr(),
                          1'($urandom_range(0, 1)), pickAddr(), pickAddr());
        end

        write_enable   = 1'b0;
        reserve_enable = 1'b0;
        rst            = 1'b0;
        for (int n = 0; n < 10 && expQ.size() != 0; n++) begin
            @(negedge clk);
        end
        #1;
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
